// File: rtl/rs485_pkg.sv
// Shared widths, idle word and small helpers for the RS485 datapath blocks.
package rs485_pkg;

    localparam int RS485_WORD_W = 16;
    localparam int RS485_BYTE_W = 8;

    localparam logic [RS485_WORD_W-1:0] RS485_IDLE_WORD = 16'h3FE0;

    // Saturating increment for byte-wide event counters.
    function automatic logic [RS485_BYTE_W-1:0] sat_inc8(input logic [RS485_BYTE_W-1:0] value);
        return (value == '1) ? value : value + RS485_BYTE_W'(1);
    endfunction

endpackage

// File: rtl/rs485_rise_detect.sv
// Registered 1-bit rising-edge detector; a level already high when reset is
// released does not count as an edge.
module rs485_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic armed;

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            in_q  <= in;
            armed <= armed | ~in;
        end
    end

    // armed stays low until the input has been seen low after reset.
    assign pulse = in & ~in_q & armed;

endmodule

// File: rtl/rs485_tx_word_fifo.sv
// Show-ahead word FIFO feeding the RS485 transmitter; presents IDLE_WORD when empty.
// Optional saturating drop/underflow counters under `RS485_FIFO_STATS_EN.
module rs485_tx_word_fifo
    import rs485_pkg::*;
#(
    parameter int                      DEPTH     = 8,
    parameter logic [RS485_WORD_W-1:0] IDLE_WORD = RS485_IDLE_WORD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [RS485_WORD_W-1:0]   wr_data,
    output logic                      full,
    input  logic                      tx_complete,
    output logic [RS485_WORD_W-1:0]   data_word,
    output logic                      word_valid,
    output logic [$clog2(DEPTH):0]    count
`ifdef RS485_FIFO_STATS_EN
    ,
    output logic [RS485_BYTE_W-1:0]   overflow_cnt,
    output logic [RS485_BYTE_W-1:0]   underflow_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [RS485_WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_nxt;
    logic                    pop_evt;
    logic                    is_empty;
    logic                    is_full;
    logic                    push_ok;
    logic                    pop_ok;

    rs485_rise_detect u_tx_done_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (tx_complete),
        .pulse (pop_evt)
    );

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    // A pop at the same edge frees the slot a push into a full FIFO needs.
    assign push_ok  = wr_en & (~is_full | pop_evt);
    assign pop_ok   = pop_evt & ~is_empty;

    // NOTE: default assigned first so no path leaves count_nxt unassigned (no latch).
    always_comb begin
        count_nxt = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_nxt;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    assign data_word  = is_empty ? IDLE_WORD : mem[rd_ptr];
    assign word_valid = ~is_empty;
    assign full       = is_full;
    assign count      = count_q;

`ifdef RS485_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_cnt  <= '0;
            underflow_cnt <= '0;
        end else begin
            if (wr_en && !push_ok)    overflow_cnt  <= sat_inc8(overflow_cnt);
            if (pop_evt && is_empty)  underflow_cnt <= sat_inc8(underflow_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_rs485_tx_word_fifo.sv
// Self-checking bench for rs485_tx_word_fifo: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_rs485_tx_word_fifo;

    localparam int          DEPTH = 8;
    localparam logic [15:0] IDLE  = 16'h3FE0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        tx_complete = 1'b0;
    logic        full;
    logic [15:0] data_word;
    logic        word_valid;
    logic [3:0]  count;
`ifdef RS485_FIFO_STATS_EN
    logic [7:0]  overflow_cnt;
    logic [7:0]  underflow_cnt;
`endif

    always #5 clk = ~clk;

    rs485_tx_word_fifo #(.DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .tx_complete (tx_complete),
        .data_word   (data_word),
        .word_valid  (word_valid),
        .count       (count)
`ifdef RS485_FIFO_STATS_EN
        ,
        .overflow_cnt  (overflow_cnt),
        .underflow_cnt (underflow_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of stored words plus the last seen tx_complete
    // level. After reset the previous level is treated as high, so a level that
    // is already high is never an edge.
    logic [15:0] model_q[$];
    bit          prev_tx = 1'b1;
    int          ovf_m = 0;
    int          unf_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit we, input logic [15:0] wd, input bit tx, input bit r);
        bit pop, was_full, was_empty, push_acc;
        if (r) begin
            model_q.delete();
            prev_tx = 1'b1;
            ovf_m   = 0;
            unf_m   = 0;
            return;
        end
        pop       = tx && !prev_tx;
        prev_tx   = tx;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        push_acc  = we && (!was_full || pop);
        if (pop && !was_empty) void'(model_q.pop_front());
        if (push_acc) model_q.push_back(wd);
        if (we && !push_acc && ovf_m < 255) ovf_m++;
        if (pop && was_empty && unf_m < 255) unf_m++;
    endtask

    task automatic check_outputs();
        int n;
        n = model_q.size();
        check("count", 32'(count), 32'(n));
        check("data_word", 32'(data_word), 32'((n != 0) ? model_q[0] : IDLE));
        check("word_valid", 32'(word_valid), 32'(n != 0));
        check("full", 32'(full), 32'(n == DEPTH));
`ifdef RS485_FIFO_STATS_EN
        check("overflow_cnt", 32'(overflow_cnt), 32'(ovf_m));
        check("underflow_cnt", 32'(underflow_cnt), 32'(unf_m));
`endif
    endtask

    // One clock: drive inputs, take the edge, then compare 1 ns after it.
    task automatic cyc(input bit we, input logic [15:0] wd, input bit tx, input bit r);
        wr_en       = we;
        wr_data     = wd;
        tx_complete = tx;
        rst         = r;
        @(posedge clk);
        model_edge(we, wd, tx, r);
        #1;
        check_outputs();
    endtask

    initial begin
        bit tx_lvl;

        // Reset and empty.
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        check("reset_data", 32'(data_word), 32'(16'h3FE0));
        check("reset_valid", 32'(word_valid), 32'(0));
        check("reset_count", 32'(count), 32'(0));
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check("empty_pop_count", 32'(count), 32'(0));

        // Push then drain.
        cyc(1'b1, 16'hA001, 1'b0, 1'b0);
        check("first_show_ahead", 32'(data_word), 32'(16'hA001));
        cyc(1'b1, 16'hA002, 1'b0, 1'b0);
        cyc(1'b1, 16'hA003, 1'b0, 1'b0);
        check("three_count", 32'(count), 32'(3));
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check("long_tx_one_pop", 32'(data_word), 32'(16'hA002));
        check("long_tx_count", 32'(count), 32'(2));
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check("second_pop", 32'(data_word), 32'(16'hA003));
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check("drained_idle", 32'(data_word), 32'(16'h3FE0));
        check("drained_valid", 32'(word_valid), 32'(0));

        // Full and overflow.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        check("full_flag", 32'(full), 32'(1));
        check("full_count", 32'(count), 32'(8));
`ifdef RS485_FIFO_STATS_EN
        check("overflow_one", 32'(overflow_cnt), 32'(1));
`endif
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(data_word), 32'(i));
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
        end
        check("drain_empty", 32'(data_word), 32'(16'h3FE0));

        // Simultaneous push and pop at full, then at empty.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
        check("full_both_count", 32'(count), 32'(8));
        check("full_both_head", 32'(data_word), 32'(16'h0101));
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
        end
        cyc(1'b1, 16'h5A5A, 1'b1, 1'b0);
        check("empty_both_count", 32'(count), 32'(1));
        check("empty_both_data", 32'(data_word), 32'(16'h5A5A));
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // Reset mid-operation with tx_complete held high.
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        check("pre_reset_count", 32'(count), 32'(5));
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        check("post_reset_count", 32'(count), 32'(0));
        check("post_reset_data", 32'(data_word), 32'(16'h3FE0));
`ifdef RS485_FIFO_STATS_EN
        check("post_reset_no_pop", 32'(underflow_cnt), 32'(0));
`endif
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // Underflow saturation.
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
            cyc(1'b0, 16'h0, 1'b0, 1'b0);
        end
        check("underflow_count_zero", 32'(count), 32'(0));
`ifdef RS485_FIFO_STATS_EN
        check("underflow_sat", 32'(underflow_cnt), 32'(8'hFF));
`endif

        // Random traffic: light then heavy push load, occasional reset.
        tx_lvl = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit we;
            bit r;
            we = (i < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) tx_lvl = ~tx_lvl;
            r = ($urandom_range(0, 199) == 0);
            cyc(we, 16'($urandom), tx_lvl, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs485_tx_word_fifo.md
Name: rs485_tx_word_fifo

Overview:
- Show-ahead 16-bit word FIFO feeding the `data` input of the RS485 transmitter/sequence-detector stage.
- The system side pushes telemetry words.
- The transmitter's `Tx_complete` pops the head word, so each detected request frame sends a fresh word.
- When empty, it presents a fixed idle word so the transmitter never sends stale or undefined data.

Parameters:
- DEPTH, 8, number of 16-bit entries; power of two, minimum 2.
- IDLE_WORD, 16'h3FE0, word presented on `data_word` while the FIFO is empty.

Ports:
- clk  input  1  system clock; one clock per RS485 bit time.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  push request, sampled on the rising edge of clk.
- wr_data  input  16  word to push.
- full  output  1  high when count == DEPTH.
- tx_complete  input  1  Tx_complete from the transmitter, level-sensitive source; its rising edge means the head word was sent.
- data_word  output  16  head word, or IDLE_WORD when empty; drives the transmitter `data` input.
- word_valid  output  1  high when data_word is a real FIFO entry (count != 0).
- count  output  $clog2(DEPTH)+1  number of stored words.

Behaviour:
- Reset, synchronous, while rst=1 at a clk edge:
  - rd_ptr = wr_ptr = 0, count = 0.
  - full = 0, word_valid = 0, data_word = IDLE_WORD.
  - tx_complete edge register cleared to 0.
  - Storage contents are not reset.
- Pop detection: a registered copy of tx_complete gives `pop_evt = tx_complete & ~tx_complete_q`.
  - Exactly one pop per rising edge, however long tx_complete stays high.
  - If rst is released while tx_complete is high, that level is not a rising edge, so no pop occurs.
- Push:
  - Accepted when wr_en=1 and (count<DEPTH or pop_evt at the same edge).
  - The word is written at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
  - Push while full with no simultaneous pop is dropped; storage and pointers are unchanged.
- Pop:
  - Accepted when pop_evt=1 and count>0; rd_ptr increments modulo DEPTH.
  - pop_evt while empty is ignored; it is an underflow.
- Simultaneous push and pop at the same edge:
  - Empty: the push is accepted, the pop is ignored, and count becomes 1.
  - Full: both are accepted and count stays DEPTH.
  - Otherwise: both are accepted and count is unchanged.
- Outputs are combinational from registered state:
  - data_word = count!=0 ? mem[rd_ptr] : IDLE_WORD.
  - word_valid = (count != 0); full = (count == DEPTH).
- Latency:
  - A word pushed into an empty FIFO at edge N appears on data_word and word_valid after edge N (zero-bubble show-ahead).
  - After a pop at edge N, the next word, or IDLE_WORD, appears after edge N.
- data_word must stay stable while the transmitter is shifting. It changes only on a push into an empty FIFO or on a pop, and pops happen only after the transmitter has completed.

Optional Feature:
- Macro RS485_FIFO_STATS_EN.
- Defined: adds outputs `overflow_cnt[7:0]` and `underflow_cnt[7:0]`.
  - overflow_cnt increments on each dropped push; underflow_cnt increments on each pop_evt while empty.
  - Both saturate at 8'hFF and clear on rst.
- Undefined: these ports and their counters do not exist; drops and underflows are silent.

Decomposition:
- Package `rs485_pkg`:
  - RS485_WORD_W = 16.
  - RS485_IDLE_WORD = 16'h3FE0, used as the parameter default.
  - RS485_BYTE_W = 8.
- Sub-module `rs485_rise_detect`: the 1-bit registered rising-edge detector (clk, rst, in, pulse). It is reusable for the Rx start-bit and Tx_complete edges elsewhere in the design.

Test Plan:
- Reset and empty: rst=1 for 1 cycle, then idle. Expect data_word=16'h3FE0, word_valid=0, count=0, full=0. A tx_complete pulse leaves count=0.
- Push then drain: push 16'hA001, 16'hA002, 16'hA003 on consecutive cycles.
  - Expect count=3 and data_word=16'hA001 the cycle after the first push.
  - Raise tx_complete for 5 cycles: exactly one pop, data_word=16'hA002, count=2.
  - Two more edges give 16'hA003, then 16'h3FE0 with word_valid=0.
- Full and overflow (DEPTH=8): push 16'h0000..16'h0007, then push 16'hFFFF.
  - Expect full=1, count=8, 16'hFFFF dropped.
  - Popping all 8 returns 0000..0007 in order, wrapping the pointers.
  - With RS485_FIFO_STATS_EN: overflow_cnt=1.
- Simultaneous push and pop:
  - At full, wr_en=1 with a tx_complete rising edge at the same edge: count stays 8 and the head advances.
  - At empty, same stimulus: count=1 and data_word equals wr_data.
- Reset mid-operation: with count=5 and tx_complete held high, assert rst for one cycle. Expect count=0 and data_word=16'h3FE0, and no pop while tx_complete stays high after reset.
- Underflow counter (RS485_FIFO_STATS_EN): give 300 tx_complete edges while empty. Expect underflow_cnt saturates at 8'hFF and count remains 0.
